// File: rtl/fish_sprite_ctrl.sv
// Fish sprite controller: position/size/facing state, AUTO patrol and MANUAL keyboard motion,
// plus registered body/tail pixel hits. Optional vertical bobbing in AUTO under `FISH_BOB_EN.
module fish_sprite_ctrl #(
  parameter int H_MIN      = 104,
  parameter int H_MAX      = 903,
  parameter int V_MIN      = 23,
  parameter int V_MAX      = 622,
  parameter int POS_W      = 12,
  parameter int TICK_DIV   = 1562500,
  parameter int STEP       = 1,
  parameter int SIZE_INIT  = 20,
  parameter int SIZE_MIN   = 10,
  parameter int SIZE_MAX   = 200,
  parameter int SIZE_STEP  = 10,
  parameter int IDLE_TICKS = 64,
  parameter int SPAWN_X    = 475,
  parameter int SPAWN_Y    = 195
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [POS_W-1:0] row,
  input  logic signed [POS_W-1:0] col,
  input  logic signed [POS_W-1:0] ini,
  input  logic [7:0]              key_data,
  input  logic                    key_valid,
  input  logic                    eat,
  output logic                    body,
  output logic                    tail,
  output logic signed [POS_W-1:0] pos_x,
  output logic signed [POS_W-1:0] pos_y,
  output logic [8:0]              radius,
  output logic                    facing,
  output logic [1:0]              mode
);

  typedef enum logic [1:0] {HIDDEN = 2'd0, AUTO = 2'd1, MANUAL = 2'd2} mode_t;

  localparam int MW = POS_W + 2;          // motion arithmetic, headroom for pos +/- radius
  localparam int GW = POS_W * 2 + 2;      // geometry arithmetic for squares
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(IDLE_TICKS + 1);

  localparam logic signed [MW-1:0] H_LO   = MW'(H_MIN);
  localparam logic signed [MW-1:0] H_HI   = MW'(H_MAX);
  localparam logic signed [MW-1:0] V_LO   = MW'(V_MIN);
  localparam logic signed [MW-1:0] V_HI   = MW'(V_MAX);
  localparam logic signed [MW-1:0] STP    = MW'(STEP);
  localparam logic signed [MW-1:0] SZ_MIN = MW'(SIZE_MIN);
  localparam logic signed [MW-1:0] SZ_MAX = MW'(SIZE_MAX);

  localparam logic [7:0] K_LEFT = 8'h6B, K_RIGHT = 8'h74, K_UP = 8'h75, K_DOWN = 8'h72;
  localparam logic [7:0] K_GROW = 8'h5A, K_SHRINK = 8'h29;

  mode_t            state, state_n;
  logic [TW-1:0]    cnt;
  logic [IW-1:0]    idle;
  logic             key_q;
  logic             tick, key_rise, key_act, is_dir, is_grow, is_shrink, active, auto_mv;
  logic signed [MW-1:0] r_cur, r_grow, r_shr, spawn_y;
  logic signed [MW-1:0] r_n, x_n, y_n;
  logic                 f_n;
`ifdef FISH_BOB_EN
  logic signed [POS_W-1:0] base_y;
  logic signed [MW-1:0]    base_n;
  logic                    bob_up, bob_n;
`endif

  assign tick      = (cnt == TW'(TICK_DIV - 1));
  assign is_dir    = (key_data == K_LEFT) || (key_data == K_RIGHT) ||
                     (key_data == K_UP)   || (key_data == K_DOWN);
  assign is_grow   = (key_data == K_GROW);
  assign is_shrink = (key_data == K_SHRINK);
  // Unrecognised codes count as no key at all, including for the idle timeout.
  assign key_act   = key_valid && (is_dir || is_grow || is_shrink);
  assign key_rise  = key_valid && !key_q;
  assign active    = eat && (state != HIDDEN);
  assign auto_mv   = tick && (state == AUTO);
  assign r_cur     = MW'(radius);
  assign r_grow    = r_cur + MW'(SIZE_STEP);
  assign r_shr     = r_cur - MW'(SIZE_STEP);
  assign spawn_y   = MW'(SPAWN_Y) + MW'(ini);
  assign mode      = state;

  // NOTE: the reset is sampled on the clock edge (synchronous), so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) state <= eat ? AUTO : HIDDEN;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      HIDDEN:  if (eat) state_n = AUTO;
      AUTO:    if (!eat) state_n = HIDDEN;
               else if (key_valid && is_dir) state_n = MANUAL;
      MANUAL:  if (!eat) state_n = HIDDEN;
               else if (tick && !key_act && idle == IW'(IDLE_TICKS - 1)) state_n = AUTO;
      default: state_n = HIDDEN;
    endcase
  end

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    r_n = r_cur;
    x_n = MW'(pos_x);
    y_n = MW'(pos_y);
    f_n = facing;
`ifdef FISH_BOB_EN
    base_n = MW'(base_y);
    bob_n  = bob_up;
`endif
    if (state == HIDDEN) begin
      if (eat) begin
        x_n = MW'(SPAWN_X);
        y_n = spawn_y;
        r_n = MW'(SIZE_INIT);
        f_n = 1'b1;
`ifdef FISH_BOB_EN
        base_n = spawn_y;
        bob_n  = 1'b0;
`endif
      end
    end else if (eat) begin
      // Resize first so any move this cycle clamps against the new radius.
      if (key_rise && is_grow)        r_n = (r_grow > SZ_MAX) ? SZ_MAX : r_grow;
      else if (key_rise && is_shrink) r_n = (r_shr < SZ_MIN) ? SZ_MIN : r_shr;
      if (auto_mv) begin
        x_n = facing ? x_n + STP : x_n - STP;
`ifdef FISH_BOB_EN
        if (bob_up) begin
          y_n = y_n - MW'(1);
          if (y_n <= base_n - MW'(8)) bob_n = 1'b0;
        end else begin
          y_n = y_n + MW'(1);
          if (y_n >= base_n + MW'(8)) bob_n = 1'b1;
        end
`endif
      end
      if (tick && state == MANUAL && key_valid) begin
        case (key_data)
          K_LEFT:  begin x_n = x_n - STP; f_n = 1'b0; end
          K_RIGHT: begin x_n = x_n + STP; f_n = 1'b1; end
          K_UP:    y_n = y_n - STP;
          K_DOWN:  y_n = y_n + STP;
          default: ;
        endcase
      end
      // Only an autonomous bump against a wall turns the fish around.
      if (x_n < H_LO + r_n) begin
        x_n = H_LO + r_n;
        if (auto_mv) f_n = 1'b1;
      end else if (x_n > H_HI - r_n) begin
        x_n = H_HI - r_n;
        if (auto_mv) f_n = 1'b0;
      end
      if (y_n < V_LO + r_n)      y_n = V_LO + r_n;
      else if (y_n > V_HI - r_n) y_n = V_HI - r_n;
    end
  end

  logic signed [GW-1:0] dx, dy, ady, rr, d;
  logic                 body_c, tail_c;

  always_comb begin
    dx     = GW'(col) - GW'(pos_x);
    dy     = GW'(row) - GW'(pos_y);
    rr     = GW'(radius);
    ady    = (dy < 0) ? -dy : dy;
    d      = facing ? (-dx - rr) : (dx - rr);
    body_c = (dx * dx + dy * dy) < (rr * rr);
    tail_c = (d > 0) && (d <= rr) && (ady <= d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x  <= POS_W'(SPAWN_X);
      pos_y  <= spawn_y[POS_W-1:0];
      radius <= 9'(SIZE_INIT);
      facing <= 1'b1;
      cnt    <= '0;
      idle   <= '0;
      key_q  <= 1'b0;
      body   <= 1'b0;
      tail   <= 1'b0;
`ifdef FISH_BOB_EN
      base_y <= spawn_y[POS_W-1:0];
      bob_up <= 1'b0;
`endif
    end else begin
      pos_x  <= x_n[POS_W-1:0];
      pos_y  <= y_n[POS_W-1:0];
      radius <= r_n[8:0];
      facing <= f_n;
      cnt    <= tick ? '0 : cnt + TW'(1);
      key_q  <= key_valid;
      if (state != MANUAL || key_act) idle <= '0;
      else if (tick)                  idle <= (idle == IW'(IDLE_TICKS - 1)) ? '0 : idle + IW'(1);
      body   <= active && body_c;
      tail   <= active && tail_c;
`ifdef FISH_BOB_EN
      base_y <= base_n[POS_W-1:0];
      bob_up <= bob_n;
`endif
    end
  end

endmodule
